// File: rtl/mux_inverter_stream.sv
// ---------------------------------------------------------------------------
// mux_inverter_stream
//
// Purpose:
//   A streaming word processor with valid/ready handshakes on both sides.
//   Each accepted word is either bitwise inverted or passed through,
//   depending on invert_en in the accept cycle. The datapath is built only
//   from 2:1 mux cells. Processed words wait in a 2-entry in-order buffer
//   until the downstream side takes them. The block also counts the words
//   and the frames that have been delivered downstream.
//
// Ports:
//   clk         in   sole clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   up_valid    in   upstream word present
//   up_ready    out  block can accept a word this cycle (registered)
//   up_data     in   [WIDTH-1:0] upstream word
//   up_last     in   upstream word ends a frame
//   invert_en   in   1 = invert the word, 0 = pass it through
//   down_valid  out  downstream word present (registered)
//   down_ready  in   downstream accepts this cycle
//   down_data   out  [WIDTH-1:0] oldest buffered word
//   down_last   out  last flag of the oldest buffered word
//   word_cnt    out  [15:0] words delivered downstream, wraps
//   frame_cnt   out  [7:0]  frames delivered downstream, wraps
// ---------------------------------------------------------------------------

// Basic 2:1 mux cell. The processing datapath is composed only of these.
module mux2 (
  input  logic sel,
  input  logic d0,
  input  logic d1,
  output logic y
);

  // sel = 0 picks d0 and sel = 1 picks d1
  assign y = sel ? d1 : d0;

endmodule

module mux_inverter_stream #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_data,
  input  logic             up_last,
  input  logic             invert_en,
  output logic             down_valid,
  input  logic             down_ready,
  output logic [WIDTH-1:0] down_data,
  output logic             down_last,
  output logic [15:0]      word_cnt,
  output logic [7:0]       frame_cnt
);

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] not_data;
  logic [WIDTH-1:0] proc_data;
  logic [WIDTH-1:0] tail_data;
  logic             tail_last;
  logic             push;
  logic             pop;

  // Per-bit datapath. The first mux uses the data bit as its select and has
  // constants 1/0 on its inputs, so it yields the inverted bit. The second
  // mux, selected by invert_en, picks either the original or the inverted bit.
  for (genvar k = 0; k < WIDTH; k++) begin : g_bit
    mux2 u_inv (
      .sel (up_data[k]),
      .d0  (1'b1),
      .d1  (1'b0),
      .y   (not_data[k])
    );

    mux2 u_sel (
      .sel (invert_en),
      .d0  (up_data[k]),
      .d1  (not_data[k]),
      .y   (proc_data[k])
    );
  end

  // Handshake qualifiers. Both ready and valid are registers, so there is
  // no combinational path from down_ready to up_ready.
  assign push = up_valid & up_ready;
  assign pop  = down_valid & down_ready;

  // Buffer FSM. The head entry sits in the down_data/down_last registers, so
  // the oldest word is always presented without an output mux. The tail entry
  // is used only in FULL. When FULL pops, the tail moves up to the head.
  // up_ready and down_valid are registered from the next state. This makes
  // up_ready rise on the first clock edge after reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      up_ready   <= 1'b0;
      down_valid <= 1'b0;
      down_data  <= '0;
      down_last  <= 1'b0;
      tail_data  <= '0;
      tail_last  <= 1'b0;
      word_cnt   <= 16'd0;
      frame_cnt  <= 8'd0;
    end else begin
      case (state)
        EMPTY: begin
          up_ready <= 1'b1;
          if (push) begin
            state      <= ONE;
            down_data  <= proc_data;
            down_last  <= up_last;
            down_valid <= 1'b1;
          end else begin
            down_valid <= 1'b0;
          end
        end
        ONE: begin
          if (push && pop) begin
            down_data <= proc_data;
            down_last <= up_last;
          end else if (push) begin
            state     <= FULL;
            tail_data <= proc_data;
            tail_last <= up_last;
            up_ready  <= 1'b0;
          end else if (pop) begin
            state      <= EMPTY;
            down_valid <= 1'b0;
          end
        end
        FULL: begin
          if (pop) begin
            state     <= ONE;
            down_data <= tail_data;
            down_last <= tail_last;
            up_ready  <= 1'b1;
          end
        end
        default: begin
          state      <= EMPTY;
          up_ready   <= 1'b0;
          down_valid <= 1'b0;
        end
      endcase

      // The delivery counters advance on each downstream transfer.
      // They wrap naturally at their widths.
      if (pop) begin
        word_cnt <= word_cnt + 16'd1;
        if (down_last) begin
          frame_cnt <= frame_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mux_inverter_stream.sv
// ---------------------------------------------------------------------------
// tb_mux_inverter_stream
//
// Purpose:
//   Self-checking bench for mux_inverter_stream with WIDTH = 8.
//   - Stimulus: directed scenarios plus randomized traffic from one initial
//     block.
//   - Scoreboard: every upstream transfer pushes its expected processed word
//     into a queue. A monitor running on the falling edge pops and compares
//     on every downstream transfer.
//   - Monitor model: the monitor also tracks the word and frame counts
//     implied by the transfers it has seen. It checks up_ready and
//     down_valid against the number of words in flight.
// ---------------------------------------------------------------------------
module tb_mux_inverter_stream;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             up_valid = 1'b0;
  logic             up_ready;
  logic [WIDTH-1:0] up_data = '0;
  logic             up_last = 1'b0;
  logic             invert_en = 1'b0;
  logic             down_valid;
  logic             down_ready = 1'b0;
  logic [WIDTH-1:0] down_data;
  logic             down_last;
  logic [15:0]      word_cnt;
  logic [7:0]       frame_cnt;

  int nChecks = 0;
  int nErrors = 0;

  // Expected words in flight, stored as {last, data}
  logic [WIDTH:0] expQ[$];
  logic [WIDTH:0] expHead;
  logic [15:0]    expWords = 16'd0;
  logic [7:0]     expFrames = 8'd0;
  logic           armed;

  mux_inverter_stream #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .up_data    (up_data),
    .up_last    (up_last),
    .invert_en  (invert_en),
    .down_valid (down_valid),
    .down_ready (down_ready),
    .down_data  (down_data),
    .down_last  (down_last),
    .word_cnt   (word_cnt),
    .frame_cnt  (frame_cnt)
  );

  // Free-running clock with a 10-unit period
  always #5 clk = ~clk;

  // One comparison: count it, and report it when it fails
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive every input in one go
  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d,
                               input logic l, input logic inv, input logic dr);
    up_valid   = v;
    up_data    = d;
    up_last    = l;
    invert_en  = inv;
    down_ready = dr;
  endtask

  // Offer one word and hold it until it is accepted, waiting at most 20
  // cycles. The task is entered and left just after a rising edge.
  task automatic sendWord(input logic [WIDTH-1:0] d, input logic l,
                          input logic inv);
    logic accepted;
    accepted = 1'b0;
    applyStimulus(1'b1, d, l, inv, down_ready);
    for (int t = 0; t < 20 && !accepted; t++) begin
      @(negedge clk);
      if (up_ready) accepted = 1'b1;
      @(posedge clk);
      #1;
    end
    up_valid = 1'b0;
    if (!accepted) checkOutput("sendWord accept timeout", 64'd0, 64'd1);
  endtask

  // Wait the given number of cycles, ending just after a rising edge
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // armed goes high once a rising edge has been seen with reset released.
  // From that point up_ready must follow the buffer occupancy.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) armed <= 1'b0;
    else        armed <= 1'b1;
  end

  // Falling-edge monitor.
  //  - During reset it checks the cleared outputs.
  //  - Otherwise it first checks the counters and the flags against the
  //    words seen so far.
  //  - It then scores the handshakes that will complete on the next rising
  //    edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      expQ.delete();
      expWords  = 16'd0;
      expFrames = 8'd0;
      checkOutput("reset down_valid", 64'(down_valid), 64'd0);
      checkOutput("reset up_ready", 64'(up_ready), 64'd0);
      checkOutput("reset word_cnt", 64'(word_cnt), 64'd0);
      checkOutput("reset frame_cnt", 64'(frame_cnt), 64'd0);
      checkOutput("reset down_data", 64'(down_data), 64'd0);
      checkOutput("reset down_last", 64'(down_last), 64'd0);
    end else begin
      checkOutput("word_cnt", 64'(word_cnt), 64'(expWords));
      checkOutput("frame_cnt", 64'(frame_cnt), 64'(expFrames));
      if (armed) begin
        checkOutput("up_ready", 64'(up_ready), 64'(expQ.size() < 2));
        checkOutput("down_valid", 64'(down_valid), 64'(expQ.size() != 0));
      end
      if (down_valid && down_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected output word", 64'(down_data), 64'hDEAD);
        end else begin
          expHead = expQ.pop_front();
          checkOutput("down_data", 64'(down_data), 64'(expHead[WIDTH-1:0]));
          checkOutput("down_last", 64'(down_last), 64'(expHead[WIDTH]));
          expWords = expWords + 16'd1;
          if (expHead[WIDTH]) expFrames = expFrames + 8'd1;
        end
      end
      if (up_valid && up_ready) begin
        expQ.push_back({up_last, invert_en ? ~up_data : up_data});
      end
    end
  end

  // Main stimulus sequence
  initial begin
    logic [WIDTH-1:0] streamWords[3];
    bit               reached;
    streamWords[0] = 8'h00;
    streamWords[1] = 8'hFF;
    streamWords[2] = 8'h3C;

    // Assert reset asynchronously, then check the outputs before any clock edge
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async reset up_ready", 64'(up_ready), 64'd0);
    checkOutput("async reset down_valid", 64'(down_valid), 64'd0);
    checkOutput("async reset word_cnt", 64'(word_cnt), 64'd0);
    idle(3);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(1);
    checkOutput("up_ready after reset release", 64'(up_ready), 64'd1);

    // Single inverted word that also ends a frame
    down_ready = 1'b1;
    sendWord(8'hA5, 1'b1, 1'b1);
    checkOutput("single down_valid", 64'(down_valid), 64'd1);
    checkOutput("single down_data", 64'(down_data), 64'h5A);
    checkOutput("single down_last", 64'(down_last), 64'd1);
    idle(1);
    checkOutput("single word_cnt", 64'(word_cnt), 64'd1);
    checkOutput("single frame_cnt", 64'(frame_cnt), 64'd1);

    // Pass-through stream with both ends always ready, one word per cycle
    foreach (streamWords[i]) begin
      sendWord(streamWords[i], 1'b0, 1'b0);
      checkOutput("stream down_valid", 64'(down_valid), 64'd1);
    end
    idle(1);
    checkOutput("stream word_cnt", 64'(word_cnt), 64'd4);

    // Backpressure: the third word must be refused until a pop frees a slot
    down_ready = 1'b0;
    sendWord(8'h11, 1'b0, 1'b0);
    sendWord(8'h22, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
    idle(1);
    checkOutput("backpressure up_ready", 64'(up_ready), 64'd0);
    checkOutput("backpressure held data", 64'(down_data), 64'h11);
    idle(1);
    checkOutput("backpressure still held", 64'(down_data), 64'h11);
    down_ready = 1'b1;
    sendWord(8'h33, 1'b1, 1'b0);
    idle(3);
    checkOutput("backpressure word_cnt", 64'(word_cnt), 64'd7);

    // A late change of invert_en must not touch a word already buffered
    down_ready = 1'b0;
    sendWord(8'h0F, 1'b0, 1'b1);
    invert_en = 1'b0;
    idle(2);
    checkOutput("late select data", 64'(down_data), 64'hF0);
    down_ready = 1'b1;
    idle(2);

    // Randomized traffic. The monitor scores every transfer.
    for (int c = 0; c < 400; c++) begin
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
      idle(1);
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    idle(4);
    checkOutput("random drain empty", 64'(expQ.size()), 64'd0);

    // Reset in the middle of a transfer, with the buffer full
    down_ready = 1'b0;
    sendWord(8'h81, 1'b0, 1'b0);
    sendWord(8'h82, 1'b1, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid reset down_valid", 64'(down_valid), 64'd0);
    checkOutput("mid reset word_cnt", 64'(word_cnt), 64'd0);
    checkOutput("mid reset frame_cnt", 64'(frame_cnt), 64'd0);
    checkOutput("mid reset up_ready", 64'(up_ready), 64'd0);
    idle(2);
    rst_n = 1'b1;
    down_ready = 1'b1;
    idle(1);
    checkOutput("post reset up_ready", 64'(up_ready), 64'd1);
    checkOutput("post reset no stale word", 64'(down_valid), 64'd0);
    sendWord(8'hC3, 1'b1, 1'b0);
    checkOutput("post reset first data", 64'(down_data), 64'hC3);
    idle(1);
    checkOutput("post reset word_cnt", 64'(word_cnt), 64'd1);

    // Stream continuously until word_cnt reads 0xFFFF, then deliver one more
    reached = 1'b0;
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 70000 && !reached; c++) begin
      up_data   = 8'($urandom);
      up_last   = 1'($urandom_range(0, 1));
      invert_en = 1'($urandom_range(0, 1));
      idle(1);
      if (word_cnt == 16'hFFFF) reached = 1'b1;
    end
    checkOutput("wrap reached 0xFFFF", 64'(reached), 64'd1);
    up_valid = 1'b0;
    checkOutput("wrap word pending", 64'(down_valid), 64'd1);
    idle(1);
    checkOutput("wrap word_cnt", 64'(word_cnt), 64'd0);
    idle(3);
    checkOutput("final drain empty", 64'(expQ.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
